instr_dispatch: RTL and testbench

INSTR_DISPATCH -- requirements
Module: instr_dispatch

---
 rtl/instr_dispatch_pkg.sv | 30 +++
 rtl/dispatch_timer.sv | 39 +++
 rtl/instr_dispatch.sv | 132 +++++++++++++
 tb/tb_instr_dispatch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_dispatch_pkg.sv
// Shared types and constants for the instruction dispatcher: FSM states,
// opcode encodings, instruction field layout and widths.
package instr_dispatch_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;
  localparam int REG_W   = 6;
  localparam int NUM_OPS = 1 << OPC_W;

  localparam int OPC_LSB = 12;
  localparam int RI_LSB  = 6;
  localparam int RJ_LSB  = 0;

  localparam logic [OPC_W-1:0] OP_MOVE = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETIRE,
    ST_ERROR
  } state_e;

  function automatic logic [NUM_OPS-1:0] opc_onehot(input logic [OPC_W-1:0] opc);
    opc_onehot      = '0;
    opc_onehot[opc] = 1'b1;
  endfunction

endpackage

// File: rtl/dispatch_timer.sv
// WAIT-state watchdog: counts cycles while enabled and flags the last
// permitted cycle so the dispatcher can declare a timeout.
module dispatch_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // count_q equals the number of WAIT cycles already elapsed, so expired
  // marks the TIMEOUT-th cycle; the counter saturates there.
  assign expired = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_dispatch.sv
// Instruction dispatcher: accepts one instruction at a time, checks the opcode
// against OP_MASK, starts the matching executor and retires it on done.
module instr_dispatch
  import instr_dispatch_pkg::*;
#(
  parameter logic [NUM_OPS-1:0] OP_MASK = 16'h0001 << OP_MOVE,
  parameter int                 TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [NUM_OPS-1:0] op_start,
  input  logic [NUM_OPS-1:0] op_done,
  output logic [REG_W-1:0]   Ri,
  output logic [REG_W-1:0]   Rj,
  output logic               retire,
  output logic [15:0]        retire_count,
  output logic               err_illegal,
  output logic               err_timeout,
  input  logic               err_clear
);

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic [REG_W-1:0]   ri_q, ri_d;
  logic [REG_W-1:0]   rj_q, rj_d;
  logic [15:0]        retire_count_q, retire_count_d;
  logic               err_illegal_q, err_illegal_d;
  logic               err_timeout_q, err_timeout_d;
  logic               timer_clear, timer_enable, timer_expired;

  dispatch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    ri_d           = ri_q;
    rj_d           = rj_q;
    retire_count_d = retire_count_q;
    err_illegal_d  = err_illegal_q;
    err_timeout_d  = err_timeout_q;
    timer_clear    = 1'b1;
    timer_enable   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          opcode_d = instr[OPC_LSB +: OPC_W];
          ri_d     = instr[RI_LSB +: REG_W];
          rj_d     = instr[RJ_LSB +: REG_W];
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (OP_MASK[opcode_q]) begin
          state_d = ST_ISSUE;
        end else begin
          err_illegal_d = 1'b1;
          state_d       = ST_ERROR;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_clear  = 1'b0;
        timer_enable = 1'b1;
        // done takes priority over a timeout landing in the same cycle
        if (op_done[opcode_q]) begin
          state_d = ST_RETIRE;
        end else if (timer_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ST_ERROR;
        end
      end
      ST_RETIRE: begin
        retire_count_d = retire_count_q + 16'd1;
        state_d        = ST_IDLE;
      end
      ST_ERROR: begin
        if (err_clear) begin
          err_illegal_d = 1'b0;
          err_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      opcode_q       <= '0;
      ri_q           <= '0;
      rj_q           <= '0;
      retire_count_q <= '0;
      err_illegal_q  <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      ri_q           <= ri_d;
      rj_q           <= rj_d;
      retire_count_q <= retire_count_d;
      err_illegal_q  <= err_illegal_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign instr_ready  = (state_q == ST_IDLE);
  assign op_start     = (state_q == ST_ISSUE) ? opc_onehot(opcode_q) : '0;
  assign retire       = (state_q == ST_RETIRE);
  assign retire_count = retire_count_q;
  assign Ri           = ri_q;
  assign Rj           = rj_q;
  assign err_illegal  = err_illegal_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed bench for instr_dispatch: MOVE, illegal opcode, timeout, done on the
// last WAIT cycle, back-to-back issue, counter wrap and reset mid-WAIT.
module tb_instr_dispatch;
  import instr_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] op_done = '0;
  logic        err_clear = 1'b0;
  logic        instr_ready;
  logic [15:0] op_start;
  logic [5:0]  Ri;
  logic [5:0]  Rj;
  logic        retire;
  logic [15:0] retire_count;
  logic        err_illegal;
  logic        err_timeout;

  int test_count = 0;
  int fail_count = 0;
  int start_pulses = 0;
  int retire_pulses = 0;

  always #5 clk = ~clk;

  instr_dispatch #(
    .OP_MASK(16'h0080),
    .TIMEOUT(15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .op_start    (op_start),
    .op_done     (op_done),
    .Ri          (Ri),
    .Rj          (Rj),
    .retire      (retire),
    .retire_count(retire_count),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .err_clear   (err_clear)
  );

  // Pulse counters, sampled just after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (op_start != 16'h0000) start_pulses++;
    if (retire) retire_pulses++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] word,
                               input logic [15:0] done, input logic clear);
    instr_valid = valid;
    instr       = word;
    op_done     = done;
    err_clear   = clear;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full MOVE with a one-cycle executor; returns in IDLE after the retire.
  task automatic runMove(input logic [15:0] word);
    applyStimulus(1'b1, word, 16'h0000, 1'b0);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(2);
    applyStimulus(1'b0, 16'h0000, 16'h0080, 1'b0);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(1);
  endtask

  initial begin
    int snap;
    int accepts;
    int acc_cyc [3];
    logic [15:0] prev_start;

    // Reset
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    checkOutput("rst_ready", instr_ready, 1);
    checkOutput("rst_op_start", op_start, 16'h0000);
    checkOutput("rst_retire", retire, 0);
    checkOutput("rst_count", retire_count, 16'h0000);
    checkOutput("rst_ri", Ri, 0);
    checkOutput("rst_rj", Rj, 0);
    checkOutput("rst_err_illegal", err_illegal, 0);
    checkOutput("rst_err_timeout", err_timeout, 0);

    // MOVE Ri=1 Rj=3, done one cycle after start
    applyStimulus(1'b1, 16'h7043, 16'h0000, 1'b0);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("move_decode_ready", instr_ready, 0);
    checkOutput("move_ri", Ri, 1);
    checkOutput("move_rj", Rj, 3);
    checkOutput("move_decode_start", op_start, 16'h0000);
    tick(1);
    checkOutput("move_issue_start", op_start, 16'h0080);
    tick(1);
    checkOutput("move_wait_start", op_start, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 16'h0080, 1'b0);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("move_retire", retire, 1);
    checkOutput("move_ri_stable", Ri, 1);
    checkOutput("move_rj_stable", Rj, 3);
    tick(1);
    checkOutput("move_retire_once", retire, 0);
    checkOutput("move_count", retire_count, 16'h0001);
    checkOutput("move_ready_again", instr_ready, 1);
    checkOutput("move_start_pulses", start_pulses, 1);

    // Illegal opcode 3; valid offered in ERROR must be ignored
    applyStimulus(1'b1, 16'h3000, 16'h0000, 1'b0);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(1);
    checkOutput("ill_flag", err_illegal, 1);
    checkOutput("ill_ready", instr_ready, 0);
    checkOutput("ill_start", op_start, 16'h0000);
    applyStimulus(1'b1, 16'h7043, 16'h0000, 1'b0);
    tick(3);
    checkOutput("ill_sticky", err_illegal, 1);
    checkOutput("ill_no_start", start_pulses, 1);
    checkOutput("ill_ri_hold", Ri, 0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("ill_cleared", err_illegal, 0);
    checkOutput("ill_idle", instr_ready, 1);

    // Timeout: no done; err_clear during WAIT must do nothing
    snap = retire_pulses;
    applyStimulus(1'b1, 16'h7043, 16'h0000, 1'b0);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(3);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(12);
    checkOutput("to_wait15_no_err", err_timeout, 0);
    checkOutput("to_wait15_busy", instr_ready, 0);
    tick(1);
    checkOutput("to_flag", err_timeout, 1);
    checkOutput("to_no_illegal", err_illegal, 0);
    checkOutput("to_ready", instr_ready, 0);
    checkOutput("to_no_retire", retire_pulses, snap);
    checkOutput("to_count", retire_count, 16'h0001);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("to_cleared", err_timeout, 0);
    checkOutput("to_idle", instr_ready, 1);

    // Done on the 15th WAIT cycle; other done bits ignored before that
    applyStimulus(1'b1, 16'h7043, 16'h0000, 1'b0);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'hFF7F, 1'b0);
    tick(15);
    checkOutput("last_no_early_retire", retire, 0);
    checkOutput("last_still_wait", instr_ready, 0);
    applyStimulus(1'b0, 16'h0000, 16'hFFFF, 1'b0);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("last_retire", retire, 1);
    checkOutput("last_no_timeout", err_timeout, 0);
    tick(1);
    checkOutput("last_count", retire_count, 16'h0002);
    checkOutput("last_idle", instr_ready, 1);

    // Back-to-back: valid held high for three MOVEs, one-cycle executor
    snap = start_pulses;
    accepts = 0;
    prev_start = 16'h0000;
    applyStimulus(1'b1, 16'h7043, 16'h0000, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (instr_valid && instr_ready) begin
        if (accepts < 3) acc_cyc[accepts] = c;
        accepts++;
      end
      tick(1);
      op_done = prev_start;
      prev_start = op_start;
      if (accepts >= 3) instr_valid = 1'b0;
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("b2b_accepts", accepts, 3);
    checkOutput("b2b_gap01", (acc_cyc[1] - acc_cyc[0]) >= 5, 1);
    checkOutput("b2b_gap12", (acc_cyc[2] - acc_cyc[1]) >= 5, 1);
    checkOutput("b2b_starts", start_pulses - snap, 3);
    checkOutput("b2b_count", retire_count, 16'h0005);

    // Wrap: preload the counter to FFFF, retire one more
    force dut.retire_count_d = 16'hFFFF;
    tick(1);
    release dut.retire_count_d;
    checkOutput("wrap_preload", retire_count, 16'hFFFF);
    runMove(16'h7043);
    checkOutput("wrap_count", retire_count, 16'h0000);

    // Reset mid-WAIT after bumping the counter to 1
    runMove(16'h7083);
    checkOutput("pre_rst_count", retire_count, 16'h0001);
    checkOutput("pre_rst_ri", Ri, 2);
    applyStimulus(1'b1, 16'h70C5, 16'h0000, 1'b0);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(3);
    checkOutput("midwait_busy", instr_ready, 0);
    snap = retire_pulses;
    reset = 1'b1;
    tick(1);
    checkOutput("midrst_start", op_start, 16'h0000);
    checkOutput("midrst_retire", retire, 0);
    checkOutput("midrst_count", retire_count, 16'h0000);
    checkOutput("midrst_ri", Ri, 0);
    checkOutput("midrst_rj", Rj, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 16'h0000, 16'h0080, 1'b0);
    tick(3);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("postrst_no_retire", retire_pulses, snap);
    checkOutput("postrst_count", retire_count, 16'h0000);
    checkOutput("postrst_ready", instr_ready, 1);
    checkOutput("postrst_errs", {err_illegal, err_timeout}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
